fp_round_pack: RTL

Final rounding and packing stage of the single-precision adder normaliser. It sits directly downstream of the mantissa preparer and consumes its 23-bit fraction and round bit, plus the sign, result exponent and special-case flags. It applies round-half-up, propagates mantissa carry into the exponent, saturates to infinity on overflow and emits a packed IEEE-754 word. It is a 2-stage pipeline with a valid/ready handshake on both sides.

---
 rtl/fp_round_pack.sv | 90 +++++++++
 1 files changed

// File: rtl/fp_round_pack.sv
// fp_round_pack: rounds, carries into the exponent, saturates and packs a binary32 result.
module fp_round_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [8:0]  in_exp,
    input  logic [22:0] in_mant,
    input  logic        in_round,
    input  logic        in_nan,
    input  logic        in_inf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact,
    output logic        out_overflow,
    output logic        out_zero
);
    logic        s1_valid_q, s1_sign_q, s1_round_q, s1_nan_q, s1_inf_q;
    logic [23:0] s1_sum_q;
    logic [9:0]  s1_exp_q;
    logic        s2_valid_q, inexact_q, overflow_q, zero_q;
    logic [31:0] data_q;
    logic        s1_load, s2_load, s1_valid_d, s2_valid_d, special, ovf;
    logic        inexact_d, overflow_d, zero_d;
    logic [9:0]  exp_adj;
    logic [22:0] frac;
    logic [31:0] data_d;

    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;

    always_comb begin
        s1_load    = in_valid && in_ready;
        s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
        s1_valid_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
        s2_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
        // A mantissa carry always leaves an all-zero fraction, so it never needs renormalising.
        exp_adj    = s1_exp_q + {9'd0, s1_sum_q[23]};
        frac       = s1_sum_q[23] ? 23'd0 : s1_sum_q[22:0];
        ovf        = exp_adj >= 10'd255;
        special    = s1_nan_q || s1_inf_q;
        data_d     = s1_nan_q ? {s1_sign_q, 8'hFF, 23'h400000} :
                     (s1_inf_q || ovf) ? {s1_sign_q, 8'hFF, 23'h0} :
                     {s1_sign_q, exp_adj[7:0], frac};
        inexact_d  = !special && s1_round_q;
        overflow_d = !special && ovf;
        zero_d     = data_d[30:0] == 31'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_round_q <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_sum_q   <= 24'd0;
            s1_exp_q   <= 10'd0;
            s2_valid_q <= 1'b0;
            data_q     <= 32'd0;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load) begin
                s1_sign_q  <= in_sign;
                s1_round_q <= in_round;
                s1_nan_q   <= in_nan;
                s1_inf_q   <= in_inf;
                s1_sum_q   <= {1'b0, in_mant} + {23'd0, in_round};
                s1_exp_q   <= {1'b0, in_exp};
            end
            if (s2_load) begin
                data_q     <= data_d;
                inexact_q  <= inexact_d;
                overflow_q <= overflow_d;
                zero_q     <= zero_d;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_data     = data_q;
    assign out_inexact  = inexact_q;
    assign out_overflow = overflow_q;
    assign out_zero     = zero_q;
endmodule
